blank_filter_rx: RTL and testbench
==================================

Name: blank_filter_rx

Overview:
- Receive-side companion of the blanking output stage.
- Accepts the word stream that stage produces, each word tagged with the blank (sanitize) flag that decided it. Discards blanked words and buffers only unblanked words in a small FIFO for a downstream consumer.
- Sits between the sanitizing transmitter and the consumer; the blank flag never reaches the output data path.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the dropped-word counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  receiver enable.
- flush  input  1  discard all buffered and in-flight words.
- in_valid  input  1  input word present.
- in_blank  input  1  word was blanked by the transmitter; drop it.
- in_data  input  WIDTH  input word.
- in_ready  output  1  receiver can accept a word this cycle.
- out_valid  output  1  FIFO head is valid.
- out_data  output  WIDTH  FIFO head word; 0 when out_valid=0.
- out_ready  input  1  consumer takes the head word.
- blank_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, FIFO empty, pointers 0, stage register cleared; in_ready=0, out_valid=0, out_data=0, blank_cnt=0.

FSM states and transitions:
- IDLE: in_ready=0. Goes to RUN when en=1 and flush=0.
- RUN: normal operation. Goes to FLUSH when flush=1 or en=0.
- FLUSH: lasts exactly 1 cycle; in_ready=0. Clears FIFO, pointers and stage register. Goes to RUN if en=1 and flush=0, else IDLE.

Accept:
- A word is accepted when in_valid && in_ready.
- Accepted words enter a one-deep stage register (s_valid, s_blank, s_data) on the next edge.
- When nothing is accepted, s_valid clears.

Filter:
- If s_valid && !s_blank, s_data is pushed into the FIFO on the following edge.
- If s_valid && s_blank, the word is discarded.
- Latency from input to out_valid for an unblanked word into an empty FIFO: 2 cycles.

in_ready:
- in_ready = (state==RUN) && (count + (s_valid && !s_blank)) < DEPTH.
- Conservative: no credit is given for a same-cycle pop.

Output:
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when valid, else 0.
- Pop when out_valid && out_ready; rd_ptr increments.

Boundary conditions:
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Full: no push is ever attempted, because in_ready guarantees space.
- Empty: out_ready is ignored.
- flush or en=0 mid-stream: the stage word and all buffered words are lost; out_valid=0 from the cycle after entering FLUSH.
- An in_valid arriving during FLUSH or IDLE is not accepted.
- rst mid-operation returns to the reset state immediately, with no partial output.

Optional Feature:
- Macro BLANK_CNT_EN.
- Defined: blank_cnt increments by 1 on each discarded blanked stage word and saturates at 2^CNT_W-1. It is cleared only by rst; FLUSH and IDLE do not clear it. Words lost to flush are not counted.
- Undefined: no counter logic is generated and blank_cnt is tied to 0.

Test Plan:
- Reset then en=1; send 0x11(blank=0), 0x22(blank=1), 0x33(blank=0), out_ready=1 -> out stream exactly 0x11, 0x33. First out_valid 2 cycles after 0x11 accepted. blank_cnt=1 with BLANK_CNT_EN, 0 without.
- DEPTH=4, out_ready=0, stream unblanked 0x01..0x06 -> in_ready drops after 4 words are accepted. FIFO holds 0x01..0x04. Then out_ready=1 drains them in order; 0x05 and 0x06 are accepted afterwards.
- Full FIFO with in_valid high and out_ready=1 for 8 cycles -> simultaneous push/pop; count stays at or below 4; output order preserved across pointer wrap.
- 3 words buffered, assert flush for 1 cycle -> next cycle out_valid=0, in_ready=0 for one cycle, then RUN. A word in the stage register is not delivered.
- With BLANK_CNT_EN and CNT_W=2, send 5 blanked words -> blank_cnt=3 (saturated), out_valid never asserts.
- rst pulsed asynchronously mid-burst (between clock edges) -> all outputs 0 immediately; after release with en=1, the block resumes accepting from an empty state.

Source files
------------

// File: rtl/blank_filter_rx.sv
// blank_filter_rx: receive side of the blanking output stage.
// Words tagged with the blank flag are dropped. All other words are buffered in a
// small FIFO for the downstream consumer.
// Optional feature: define BLANK_CNT_EN to build the saturating dropped-word
// counter on blank_cnt. When BLANK_CNT_EN is undefined, blank_cnt is tied to 0.
//
// state | meaning
// IDLE  | receiver disabled, in_ready low
// RUN   | accepting, filtering and buffering words
// FLUSH | one cycle: stage, FIFO and pointers are cleared, in_ready low
module blank_filter_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_blank,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blank_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic              s_valid;
    logic              s_blank;
    logic [WIDTH-1:0]  s_data;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              clr;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW:0]       occ;

    // Handshake, filter and output decode. Leaving RUN also clears the buffer on
    // that same edge, so buffered data disappears as soon as FLUSH is entered.
    always_comb begin
        clr       = (state != RUN) || flush || !en;
        push      = s_valid && !s_blank && !clr;
        pop       = (count != '0) && out_ready && !clr;
        occ       = {1'b0, count} + {{CW{1'b0}}, (s_valid && !s_blank)};
        in_ready  = (state == RUN) && (occ < DEPTH_L);
        accept    = in_valid && in_ready;
        out_valid = (count != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en && !flush) state <= RUN;
                RUN:     if (flush || !en) state <= FLUSH;
                FLUSH:   state <= (en && !flush) ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-deep stage register in front of the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_blank <= 1'b0;
            s_data  <= '0;
        end else if (clr) begin
            s_valid <= 1'b0;
            s_blank <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= accept;
            if (accept) begin
                s_blank <= in_blank;
                s_data  <= in_data;
            end
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. Contents need no reset because out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

`ifdef BLANK_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Count discarded blanked words. Words lost to a flush are not counted. Only rst clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s_valid && s_blank && !clr && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blank_cnt = cnt;
`else
    assign blank_cnt = '0;
`endif

endmodule

// File: tb/tb_blank_filter_rx.sv
// Testbench for blank_filter_rx. It uses a per-cycle vector table for the basic stream.
// A scoreboard queue checks ordering in the multi-cycle sequences.
module tb_blank_filter_rx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_blank = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] blank_cnt;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [WIDTH-1:0] exp_q [$];

    typedef struct {
        logic             iv;
        logic             ib;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             exp_ir;
        logic             exp_ov;
        logic [WIDTH-1:0] exp_od;
    } vec_t;

    vec_t tbl [6];

    blank_filter_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_blank  (in_blank),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .blank_cnt (blank_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef BLANK_CNT_EN
        return (model_cnt > 3) ? 32'd3 : 32'(model_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard: compare every word the consumer takes against the expected order.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none (t=%0t)", out_data, $time);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_order actual=%0h required=%0h (t=%0t)", out_data, e, $time);
                    end
                end
            end else if (!out_valid) begin
                chk("out_data_idle_zero", 32'(out_data), 32'd0);
            end
        end
    end

    // Hold a word until it is accepted. Called and returns at posedge+1.
    task automatic send(input logic [WIDTH-1:0] d, input logic b);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_blank = b;
        in_data  = d;
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) begin
                done = 1'b1;
                if (b) model_cnt++;
                else exp_q.push_back(d);
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_blank = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        tbl[0] = '{iv: 1'b1, ib: 1'b0, id: 8'h11, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_od: 8'h00};
        tbl[1] = '{iv: 1'b1, ib: 1'b1, id: 8'h22, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_od: 8'h00};
        tbl[2] = '{iv: 1'b1, ib: 1'b0, id: 8'h33, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_od: 8'h11};
        tbl[3] = '{iv: 1'b0, ib: 1'b0, id: 8'h00, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_od: 8'h00};
        tbl[4] = '{iv: 1'b0, ib: 1'b0, id: 8'h00, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_od: 8'h33};
        tbl[5] = '{iv: 1'b0, ib: 1'b0, id: 8'h00, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_od: 8'h00};

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_blank_cnt", 32'(blank_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;

        // Test 1: basic filtered stream, table driven
        for (int i = 0; i < 6; i++) begin
            in_valid  = tbl[i].iv;
            in_blank  = tbl[i].ib;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            if (tbl[i].iv && in_ready) begin
                if (tbl[i].ib) model_cnt++;
                else exp_q.push_back(tbl[i].id);
            end
            @(negedge clk);
            chk($sformatf("t1_in_ready_%0d", i), 32'(in_ready), 32'(tbl[i].exp_ir));
            chk($sformatf("t1_out_valid_%0d", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("t1_out_data_%0d", i), 32'(out_data), 32'(tbl[i].exp_od));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_blank_cnt", 32'(blank_cnt), exp_cnt());

        // Test 2: fill to DEPTH with the consumer stalled, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        in_data = 8'h05;
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_in_ready_full2", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t2_head_valid", 32'(out_valid), 32'd1);
        chk("t2_head_data", 32'(out_data), 32'h01);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        wait_drain();

        // Test 3: full FIFO with continuous push and pop across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b0);
        idle(2);
        out_ready = 1'b1;
        for (int i = 4; i < 12; i++) send(8'h41 + 8'(i), 1'b0);
        wait_drain();

        // Test 4: flush with three buffered words and one word in the stage register
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1'b0);
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
        chk("t4_flush_in_ready", 32'(in_ready), 32'd0);
        chk("t4_flush_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_run_in_ready", 32'(in_ready), 32'd1);
        chk("t4_run_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h5A, 1'b0);
        wait_drain();

        // Test 5: blanked words only, so the counter saturates and nothing is output
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i), 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_out_valid_%0d", i), 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("t5_blank_cnt_sat", 32'(blank_cnt), exp_cnt());

        // Test 6: asynchronous reset in the middle of a burst
        out_ready = 1'b0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_data", 32'(out_data), 32'd0);
        chk("t6_rst_blank_cnt", 32'(blank_cnt), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_resume_in_ready", 32'(in_ready), 32'd1);
        chk("t6_resume_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(8'h77, 1'b0);
        wait_drain();
        chk("t6_blank_cnt", 32'(blank_cnt), exp_cnt());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
